// File: rtl/sram_rd_arbiter_if.sv
//==============================================================================
// Module   : sram_rd_arbiter_if
// Purpose  : Bundles both engine request/response channels and the shared SRAM
//            read port that sram_rd_arbiter sits between.
// Ports    : req/lock/addr   engine -> arbiter request, per requester 0/1
//            gnt             arbiter -> engine, port owned this cycle
//            rvalid/rdata    arbiter -> engine, read data one cycle later
//            dut_sram_read_address / sram_dut_read_data  SRAM read port
// Modports : master - engines and SRAM model (drive requests, SRAM data)
//            slave  - arbiter
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

interface sram_rd_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              req0;
  logic              lock0;
  logic [ADDR_W-1:0] addr0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              lock1;
  logic [ADDR_W-1:0] addr1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] dut_sram_read_address;
  logic [DATA_W-1:0] sram_dut_read_data;

  modport master (
    output req0, lock0, addr0, req1, lock1, addr1, sram_dut_read_data,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, dut_sram_read_address
  );

  modport slave (
    input  req0, lock0, addr0, req1, lock1, addr1, sram_dut_read_data,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, dut_sram_read_address
  );
endinterface

`default_nettype wire

// File: rtl/sram_rd_arbiter.sv
//==============================================================================
// Module   : sram_rd_arbiter
// Purpose  : Shares one synchronous-read SRAM port (1-cycle latency) between
//            two convolution engines. Round-robin arbitration with an optional
//            bounded lock; read data is steered back to the issuing requester.
// Ports    : clk      clock, rising edge
//            reset_b  asynchronous reset, active HIGH despite the name
//            bus      sram_rd_arbiter_if.slave (requests, grants, read data,
//                     SRAM address/data)
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module sram_rd_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter int MAX_HOLD = 16   // 1..255
) (
  input  logic                 clk,
  input  logic                 reset_b,
  sram_rd_arbiter_if.slave     bus
);

  localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);

  // Used both for the lock owner and for the owner of the read in flight.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_0    = 2'd1,
    OWN_1    = 2'd2
  } owner_e;

  owner_e              lock_own_q, lock_own_d;
  owner_e              tag_q,      tag_d;
  logic                ptr_q,      ptr_d;
  logic [7:0]          hold_cnt_q, hold_cnt_d;
  logic [ADDR_W-1:0]   last_addr_q, last_addr_d;

  logic                w_cont0, w_cont1;
  logic                w_gnt0,  w_gnt1;
  logic                w_lock_gnt;
  owner_e              w_gnt_own;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_rdata0, w_rdata1;

  //--------------------------------------------------------------------------
  // Grant. A lock owner keeps the port until it has used MAX_HOLD locked
  // grants while the other side waits; at that point the normal round-robin
  // path runs, and since every locked grant already moved ptr to the waiter,
  // the waiter wins (forced switch).
  //--------------------------------------------------------------------------
  always_comb begin
    w_cont0 = (lock_own_q == OWN_0) && bus.req0 &&
              ((hold_cnt_q < c_max_hold) || !bus.req1);
    w_cont1 = (lock_own_q == OWN_1) && bus.req1 &&
              ((hold_cnt_q < c_max_hold) || !bus.req0);
    w_gnt0  = 1'b0;
    w_gnt1  = 1'b0;
    // No grant may leave the block while reset is held.
    if (!reset_b) begin
      if (w_cont0) begin
        w_gnt0 = 1'b1;
      end else if (w_cont1) begin
        w_gnt1 = 1'b1;
      end else if (bus.req0 && bus.req1) begin
        if (ptr_q) w_gnt1 = 1'b1;
        else       w_gnt0 = 1'b1;
      end else if (bus.req0) begin
        w_gnt0 = 1'b1;
      end else if (bus.req1) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Next-state: pointer, lock, in-flight tag, held address.
  //--------------------------------------------------------------------------
  always_comb begin
    w_gnt_own   = w_gnt0 ? OWN_0 : OWN_1;
    w_lock_gnt  = (w_gnt0 && bus.lock0) || (w_gnt1 && bus.lock1);
    w_addr      = w_gnt0 ? bus.addr0 : (w_gnt1 ? bus.addr1 : last_addr_q);

    ptr_d       = ptr_q;
    last_addr_d = last_addr_q;
    lock_own_d  = OWN_NONE;
    hold_cnt_d  = 8'd0;
    tag_d       = OWN_NONE;

    if (w_gnt0 || w_gnt1) begin
      ptr_d       = w_gnt0;          // priority passes to the other requester
      last_addr_d = w_addr;
      tag_d       = w_gnt_own;
      // Only the granted requester's lock counts; a lock from the loser is
      // ignored because w_lock_gnt is qualified by the grant.
      if (w_lock_gnt) begin
        lock_own_d = w_gnt_own;
        if (lock_own_q == w_gnt_own) begin
          hold_cnt_d = (hold_cnt_q < c_max_hold) ? hold_cnt_q + 8'd1 : c_max_hold;
        end else begin
          hold_cnt_d = 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      ptr_q       <= 1'b0;
      lock_own_q  <= OWN_NONE;
      hold_cnt_q  <= 8'd0;
      tag_q       <= OWN_NONE;
      last_addr_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      lock_own_q  <= lock_own_d;
      hold_cnt_q  <= hold_cnt_d;
      tag_q       <= tag_d;
      last_addr_q <= last_addr_d;
    end
  end

  //--------------------------------------------------------------------------
  // Response steering: the SRAM returns data the cycle after the address, so
  // the registered tag selects which requester sees it.
  //--------------------------------------------------------------------------
  always_comb begin
    w_rdata0 = (tag_q == OWN_0) ? bus.sram_dut_read_data : '0;
    w_rdata1 = (tag_q == OWN_1) ? bus.sram_dut_read_data : '0;
  end

  assign bus.gnt0                  = w_gnt0;
  assign bus.gnt1                  = w_gnt1;
  assign bus.dut_sram_read_address = w_addr;
  assign bus.rvalid0               = (tag_q == OWN_0);
  assign bus.rvalid1               = (tag_q == OWN_1);
  assign bus.rdata0                = w_rdata0;
  assign bus.rdata1                = w_rdata1;

endmodule

`default_nettype wire

// File: tb/tb_sram_rd_arbiter.sv
//==============================================================================
// Module   : tb_sram_rd_arbiter
// Purpose  : Self-checking bench for sram_rd_arbiter (MAX_HOLD = 4) with a
//            behavioural SRAM and an arbitration reference model.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_sram_rd_arbiter;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 16;
  localparam int MAX_HOLD = 4;

  logic clk;
  logic reset_b;

  sram_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_rd_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk    (clk),
    .reset_b(reset_b),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: one-cycle synchronous read.
  logic [DATA_W-1:0] mem [1 << ADDR_W];
  always @(posedge clk) bus.sram_dut_read_data <= mem[bus.dut_sram_read_address];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state, in plain integers (-1 = nobody).
  int              m_owner;
  int              m_hold;
  int              m_prio;
  int              m_inflight;
  logic [ADDR_W-1:0] m_inflight_addr;
  logic [ADDR_W-1:0] m_last_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cyc=%0d %s got=%0h exp=%0h", cyc, tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner         = -1;
    m_hold          = 0;
    m_prio          = 0;
    m_inflight      = -1;
    m_inflight_addr = '0;
    m_last_addr     = '0;
  endtask

  // One bus cycle: drive at the falling edge, check combinational outputs
  // shortly after, then advance the model to what the next rising edge does.
  task automatic step(input logic rst,
                      input logic r0, input logic l0, input logic [ADDR_W-1:0] a0,
                      input logic r1, input logic l1, input logic [ADDR_W-1:0] a1);
    logic              rq [2];
    logic              lk [2];
    logic [ADDR_W-1:0] ad [2];
    int                g;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_d0, exp_d1;
    @(negedge clk);
    cyc++;
    reset_b   = rst;
    bus.req0  = r0; bus.lock0 = l0; bus.addr0 = a0;
    bus.req1  = r1; bus.lock1 = l1; bus.addr1 = a1;
    rq[0] = r0; rq[1] = r1; lk[0] = l0; lk[1] = l1; ad[0] = a0; ad[1] = a1;
    #1;
    if (rst) model_reset();

    g = -1;
    if (!rst) begin
      if (m_owner >= 0 && rq[m_owner] && (m_hold < MAX_HOLD || !rq[1 - m_owner]))
        g = m_owner;
      else if (rq[0] && rq[1])
        g = m_prio;
      else if (rq[0])
        g = 0;
      else if (rq[1])
        g = 1;
    end
    exp_addr = (g >= 0) ? ad[g] : m_last_addr;
    exp_d0   = (m_inflight == 0) ? mem[m_inflight_addr] : '0;
    exp_d1   = (m_inflight == 1) ? mem[m_inflight_addr] : '0;

    chk("gnt0",    32'(bus.gnt0),    32'(g == 0));
    chk("gnt1",    32'(bus.gnt1),    32'(g == 1));
    chk("addr",    32'(bus.dut_sram_read_address), 32'(exp_addr));
    chk("rvalid0", 32'(bus.rvalid0), 32'(m_inflight == 0));
    chk("rvalid1", 32'(bus.rvalid1), 32'(m_inflight == 1));
    chk("rdata0",  32'(bus.rdata0),  32'(exp_d0));
    chk("rdata1",  32'(bus.rdata1),  32'(exp_d1));

    if (!rst) begin
      m_inflight      = g;
      m_inflight_addr = exp_addr;
      if (g >= 0) begin
        m_last_addr = ad[g];
        m_prio      = 1 - g;
        if (lk[g]) begin
          m_hold  = (m_owner == g) ? ((m_hold + 1 > MAX_HOLD) ? MAX_HOLD : m_hold + 1) : 1;
          m_owner = g;
        end else begin
          m_owner = -1;
          m_hold  = 0;
        end
      end else begin
        m_owner = -1;
        m_hold  = 0;
      end
    end
  endtask

  int gnt0_run;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'($urandom);
    mem[12'h010] = 16'h00FF;
    mem[12'h123] = 16'hBEEF;

    reset_b  = 1'b1;
    bus.req0 = 0; bus.lock0 = 0; bus.addr0 = '0;
    bus.req1 = 0; bus.lock1 = 0; bus.addr1 = '0;
    model_reset();

    // Reset held, then idle.
    repeat (2) step(1, 1, 0, 12'h055, 1, 0, 12'h066);
    repeat (3) step(0, 0, 0, '0, 0, 0, '0);

    // Single read from requester 0.
    step(0, 1, 0, 12'h010, 0, 0, 12'h000);
    step(0, 0, 0, 12'h000, 0, 0, 12'h000);
    chk("plan_rdata0_00FF", 32'(bus.rdata0), 32'h00FF);

    // Both requesting, no lock: alternation.
    for (int i = 0; i < 8; i++)
      step(0, 1, 0, 12'(12'h100 + i), 1, 0, 12'(12'h200 + i));
    step(0, 0, 0, '0, 0, 0, '0);

    // Locked requester 0 against a waiting requester 1.
    gnt0_run = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 1, 12'(12'h300 + i), 1, 0, 12'(12'h400 + i));
      if (i < 5) gnt0_run += int'(bus.gnt0);
    end
    chk("plan_lock_run", 32'(gnt0_run), 32'(MAX_HOLD));
    step(0, 0, 0, '0, 0, 0, '0);

    // Lock with the other side idle: saturates, then yields when it requests.
    for (int i = 0; i < 10; i++) step(0, 1, 1, 12'(12'h500 + i), 0, 0, '0);
    step(0, 1, 1, 12'h50A, 1, 0, 12'h600);
    chk("plan_yield_gnt1", 32'(bus.gnt1), 32'd1);
    step(0, 0, 0, '0, 0, 0, '0);

    // Reset right as requester 1's read would return.
    step(0, 0, 0, '0, 1, 0, 12'h123);
    @(posedge clk);
    reset_b  = 1'b1;
    bus.req1 = 1'b0;
    #1;
    model_reset();
    chk("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
    chk("rst_rdata1",  32'(bus.rdata1),  32'd0);
    step(1, 0, 0, '0, 0, 0, '0);
    step(0, 1, 0, 12'h011, 1, 0, 12'h022);
    chk("plan_post_rst_gnt0", 32'(bus.gnt0), 32'd1);
    step(0, 0, 0, '0, 0, 0, '0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 5), 12'($urandom),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 5), 12'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
